// File: rtl/inv_butterfly_pipe.sv
// -----------------------------------------------------------------------------
// inv_butterfly_pipe
//
// Gentleman-Sande (inverse-NTT) butterfly, three pipeline stages:
//   a0 = (x0 + x1) mod Q
//   a1 = ((x0 - x1) * w) mod Q
//
// Stage 1 : modular add / subtract, twiddle registered
// Stage 2 : full 2*WIDTH product d*w, sum forwarded
// Stage 3 : exact reduction of the product, results registered onto a0/a1
//
// All stages advance together on adv = ~s3_valid | out_ready, so a stalled
// output freezes the whole pipe and nothing is lost or duplicated.
// Bubbles travel as valid = 0; their data content is don't-care.
//
// Optional feature (macro INV_BFLY_HALVE_EN):
//   When defined, both results are multiplied by 2^-1 mod Q, folding the
//   INTT n^-1 scaling into each stage. The sum is halved in stage 2 and the
//   reduced product in stage 3, so latency stays at 3 cycles.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      x0/x1/w valid
//   in_ready   out  1      operand set accepted this cycle if in_valid
//   x0         in   WIDTH  upper coefficient  [0,Q-1]
//   x1         in   WIDTH  lower coefficient  [0,Q-1]
//   w          in   WIDTH  inverse twiddle    [0,Q-1]
//   out_valid  out  1      a0/a1 valid
//   out_ready  in   1      downstream accepts a0/a1
//   a0         out  WIDTH  (x0+x1) mod Q
//   a1         out  WIDTH  ((x0-x1)*w) mod Q
// -----------------------------------------------------------------------------
module inv_butterfly_pipe #(
    parameter int WIDTH = 32,
    parameter int Q     = 7681
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a0,
    output logic [WIDTH-1:0] a1
);

    localparam logic [WIDTH:0]     Q_EXT  = (WIDTH+1)'(Q);
    localparam logic [WIDTH-1:0]   Q_N    = WIDTH'(Q);
    localparam logic [2*WIDTH-1:0] Q_PROD = (2*WIDTH)'(Q);

`ifdef INV_BFLY_HALVE_EN
    // Multiply by 2^-1 mod Q: an odd value becomes even after adding the
    // odd modulus, so the shift is exact. v < Q < 2^(WIDTH-1) keeps v+Q
    // inside WIDTH+1 bits.
    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] t;
        t = v[0] ? ({1'b0, v} + Q_EXT) : {1'b0, v};
        return t[WIDTH:1];
    endfunction
`endif

    // Pipeline registers
    logic                 s1_valid_q, s2_valid_q, s3_valid_q;
    logic [WIDTH-1:0]     s1_s_q, s1_d_q, s1_w_q;
    logic [WIDTH-1:0]     s2_s_q;
    logic [2*WIDTH-1:0]   s2_p_q;
    logic [WIDTH-1:0]     s3_a0_q, s3_a1_q;

    // Next-state values
    logic [WIDTH:0]       sum_full;
    logic [WIDTH-1:0]     s1_s_d, s1_d_d;
    logic [WIDTH-1:0]     s2_s_d;
    logic [2*WIDTH-1:0]   s2_p_d;
    logic [WIDTH-1:0]     s3_a1_d;
    logic                 adv;

    assign adv      = ~s3_valid_q | out_ready;
    assign in_ready = adv;

    always_comb begin
        // Stage 1: modular add and subtract. The WIDTH-bit subtraction wraps
        // modulo 2^WIDTH, so adding Q after a borrow lands back in [1,Q-1].
        sum_full = {1'b0, x0} + {1'b0, x1};
        s1_s_d   = (sum_full >= Q_EXT) ? WIDTH'(sum_full - Q_EXT) : WIDTH'(sum_full);
        s1_d_d   = (x0 < x1) ? (x0 - x1 + Q_N) : (x0 - x1);

        // Stage 2: full-width product, sum forwarded (halved if enabled)
        s2_p_d = {{WIDTH{1'b0}}, s1_d_q} * {{WIDTH{1'b0}}, s1_w_q};
`ifdef INV_BFLY_HALVE_EN
        s2_s_d = half_mod(s1_s_q);
`else
        s2_s_d = s1_s_q;
`endif

        // Stage 3: exact reduction; the remainder is < Q so it fits in WIDTH
`ifdef INV_BFLY_HALVE_EN
        s3_a1_d = half_mod(WIDTH'(s2_p_q % Q_PROD));
`else
        s3_a1_d = WIDTH'(s2_p_q % Q_PROD);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_s_q     <= '0;
            s1_d_q     <= '0;
            s1_w_q     <= '0;
            s2_s_q     <= '0;
            s2_p_q     <= '0;
            s3_a0_q    <= '0;
            s3_a1_q    <= '0;
        end else if (adv) begin
            // in_ready equals adv, so in_valid alone marks an accepted set here
            s1_valid_q <= in_valid;
            s1_s_q     <= s1_s_d;
            s1_d_q     <= s1_d_d;
            s1_w_q     <= w;

            s2_valid_q <= s1_valid_q;
            s2_s_q     <= s2_s_d;
            s2_p_q     <= s2_p_d;

            s3_valid_q <= s2_valid_q;
            s3_a0_q    <= s2_s_q;
            s3_a1_q    <= s3_a1_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign a0        = s3_a0_q;
    assign a1        = s3_a1_q;

endmodule

// File: tb/tb_inv_butterfly_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for inv_butterfly_pipe (WIDTH=32, Q=7681).
// Expected results come from modular arithmetic on integers; with
// INV_BFLY_HALVE_EN they are multiplied by the modular inverse of 2.
// A FIFO scoreboard holds expected results in acceptance order.
// -----------------------------------------------------------------------------
module tb_inv_butterfly_pipe;

    localparam int WIDTH = 32;
    localparam int Q     = 7681;
    localparam longint INV2 = (Q + 1) / 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x0, x1, w;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a0, a1;

    inv_butterfly_pipe #(.WIDTH(WIDTH), .Q(Q)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0        (x0),
        .x1        (x1),
        .w         (w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a0        (a0),
        .a1        (a1)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint exp_a0_q[$];
    longint exp_a1_q[$];
    logic   hold_pend = 1'b0;
    logic [WIDTH-1:0] hold_a0, hold_a1;
    logic   acc_flag;
    int     out_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_a0(input longint p, input longint q);
        longint r;
        r = (p + q) % Q;
`ifdef INV_BFLY_HALVE_EN
        r = (r * INV2) % Q;
`endif
        return r;
    endfunction

    function automatic longint ref_a1(input longint p, input longint q, input longint tw);
        longint r;
        r = (((p - q + Q) % Q) * tw) % Q;
`ifdef INV_BFLY_HALVE_EN
        r = (r * INV2) % Q;
`endif
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_coef();
        int sel;
        sel = $urandom_range(7, 0);
        if (sel == 0) return WIDTH'(Q - 1);
        if (sel == 1) return '0;
        return WIDTH'($urandom_range(Q - 1, 0));
    endfunction

    // One clock cycle: entered 1 time unit after a rising edge with inputs
    // already driven; samples mid-cycle, updates the scoreboard, and returns
    // 1 time unit after the next rising edge.
    task automatic cycle();
        #2;
        chk("in_ready_rule", in_ready, (!out_valid || out_ready));
        if (hold_pend) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_a0", a0, hold_a0);
            chk("hold_a1", a1, hold_a1);
        end
        hold_pend = out_valid && !out_ready && !rst;
        hold_a0   = a0;
        hold_a1   = a1;
        if (out_valid && out_ready && !rst) begin
            if (exp_a0_q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                chk("a0", a0, exp_a0_q.pop_front());
                chk("a1", a1, exp_a1_q.pop_front());
                out_cnt++;
            end
        end
        acc_flag = in_valid && in_ready && !rst;
        if (acc_flag) begin
            exp_a0_q.push_back(ref_a0(x0, x1));
            exp_a1_q.push_back(ref_a1(x0, x1, w));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int p, input int q, input int tw);
        in_valid = v;
        x0 = WIDTH'(p);
        x1 = WIDTH'(q);
        w  = WIDTH'(tw);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_a0_q.size() != 0 && n < 50) begin
            cycle();
            n++;
        end
        chk(tag, exp_a0_q.size(), 0);
    endtask

    initial begin
        int sent, base_cnt, cyc;

        // ---------------- reset ----------------
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_held_out_valid", out_valid, 0);
        rst = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_a0", a0, 0);
        chk("rst_a1", a1, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // ---------------- single set, latency 3 ----------------
        drive(1'b1, 1, 3, 1);
        cycle();
        drive(1'b0, 0, 0, 0);
        #1; chk("lat_c1_valid", out_valid, 0); cycle();
        #1; chk("lat_c2_valid", out_valid, 0); cycle();
        #1;
        chk("lat_c3_valid", out_valid, 1);
`ifdef INV_BFLY_HALVE_EN
        chk("lat_a0", a0, 2);
        chk("lat_a1", a1, 7680);
`else
        chk("lat_a0", a0, 4);
        chk("lat_a1", a1, 7679);
`endif
        cycle();
        #1; chk("lat_after_valid", out_valid, 0); cycle();

        // ---------------- back-to-back ----------------
        drive(1'b1, 1, 3, 1); cycle();
        drive(1'b1, 2, 4, 3); cycle();
        drive(1'b0, 0, 0, 0); cycle();
        #1;
`ifdef INV_BFLY_HALVE_EN
        chk("b2b_1_a0", a0, 2);
        chk("b2b_1_a1", a1, 7680);
`else
        chk("b2b_1_a0", a0, 4);
        chk("b2b_1_a1", a1, 7679);
`endif
        cycle();
        #1;
        chk("b2b_2_valid", out_valid, 1);
`ifdef INV_BFLY_HALVE_EN
        chk("b2b_2_a0", a0, 3);
        chk("b2b_2_a1", a1, 7678);
`else
        chk("b2b_2_a0", a0, 6);
        chk("b2b_2_a1", a1, 7675);
`endif
        cycle();
        drain("b2b_drain");

        // ---------------- wrap ----------------
        drive(1'b1, 7680, 5, 2); cycle();
        drive(1'b0, 0, 0, 0); cycle(); cycle();
        #1;
        chk("wrap_valid", out_valid, 1);
`ifdef INV_BFLY_HALVE_EN
        chk("wrap_a0", a0, 2);
        chk("wrap_a1", a1, 7675);
`else
        chk("wrap_a0", a0, 4);
        chk("wrap_a1", a1, 7669);
`endif
        cycle();
        drain("wrap_drain");

        // ---------------- backpressure: 6 sets, 4-cycle stall ----------------
        base_cnt = out_cnt;
        sent = 0;
        cyc  = 0;
        drive(1'b1, rnd_coef(), rnd_coef(), rnd_coef());
        while ((sent < 6 || exp_a0_q.size() != 0) && cyc < 60) begin
            in_valid  = (sent < 6);
            out_ready = !(cyc >= 4 && cyc <= 7);
            if (cyc == 7) begin
                #1;
                chk("bp_in_ready_full", in_ready, 0);
                chk("bp_valid_full", out_valid, 1);
            end
            cycle();
            if (acc_flag) begin
                sent++;
                drive(1'b1, rnd_coef(), rnd_coef(), rnd_coef());
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_sent", sent, 6);
        chk("bp_emitted", out_cnt - base_cnt, 6);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 300; i++) begin
            if (!in_valid || acc_flag)
                drive($urandom_range(3, 0) != 0, rnd_coef(), rnd_coef(), rnd_coef());
            out_ready = ($urandom_range(2, 0) != 0);
            cycle();
        end
        drain("rand_drain");

        // ---------------- reset mid-stream ----------------
        out_ready = 1'b0;
        drive(1'b1, rnd_coef(), rnd_coef(), rnd_coef()); cycle();
        drive(1'b1, rnd_coef(), rnd_coef(), rnd_coef()); cycle();
        drive(1'b0, 0, 0, 0); cycle();
        #1;
        chk("rstmid_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_a0", a0, 0);
        chk("rstmid_a1", a1, 0);
        exp_a0_q.delete();
        exp_a1_q.delete();
        hold_pend = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("rstmid_no_stale", out_valid, 0);
            cycle();
        end

        // one fresh set after reset still works
        drive(1'b1, 7680, 7680, 7680); cycle();
        drive(1'b0, 0, 0, 0);
        drain("post_rst_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
